// File: rtl/vga_timing_monitor.sv
// Receive-side VGA raster checker: measures line/frame/sync timing on pix_en cycles,
// declares lock after consecutive matching frames and captures one programmable pixel.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_SYNC      = 96,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [7:0]    red_in,
  input  logic [7:0]    green_in,
  input  logic [7:0]    blue_in,
  input  logic [CW-1:0] sample_x,
  input  logic [CW-1:0] sample_y,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] h_sync_w,
  output logic [CW-1:0] v_sync_w,
  output logic          locked,
  output logic          frame_done,
  output logic          timing_err,
  output logic [23:0]   sample_rgb,
  output logic          sample_valid
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
  localparam logic [MW-1:0] LOCK_C    = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CW-1:0] hs_w_q, hs_w_d, vs_w_q, vs_w_d;
  logic [CW-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [CW-1:0] h_sync_w_q, h_sync_w_d, v_sync_w_q, v_sync_w_d;
  logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic          line_bad_q, line_bad_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic          frame_done_q, frame_done_d, timing_err_q, timing_err_d;
  logic          sample_valid_q, sample_valid_d;
  logic [23:0]   sample_rgb_q, sample_rgb_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  logic          hs_rise, hs_fall, vs_rise, vs_fall, in_meas, line_err, frame_ok;
  logic [CW-1:0] h_idx, v_idx, h_meas, v_meas;

  assign hs_rise  = hsync_in & ~hs_prev_q;
  assign hs_fall  = ~hsync_in & hs_prev_q;
  assign vs_rise  = vsync_in & ~vs_prev_q;
  assign vs_fall  = ~vsync_in & vs_prev_q;
  assign in_meas  = (state_q != S_SEARCH);
  assign h_meas   = h_cnt_q + CW'(1);
  assign v_meas   = v_cnt_q + CW'(1);
  // Index of the current pixel/line; a coincident vsync rise makes this line 0.
  assign h_idx    = hs_rise ? '0 : sat_inc(h_cnt_q);
  assign v_idx    = vs_rise ? '0 : (hs_rise ? sat_inc(v_cnt_q) : v_cnt_q);
  assign line_err = hs_rise & in_meas & (h_meas != H_TOTAL_C);
  assign frame_ok = (v_meas == V_TOTAL_C) && !(line_bad_q | line_err) &&
                    (h_sync_w_q == H_SYNC_C) && (v_sync_w_q == V_SYNC_C);

  always_comb begin
    state_d        = state_q;
    h_cnt_d        = h_cnt_q;
    v_cnt_d        = v_cnt_q;
    hs_w_d         = hs_w_q;
    vs_w_d         = vs_w_q;
    h_total_d      = h_total_q;
    v_total_d      = v_total_q;
    h_sync_w_d     = h_sync_w_q;
    v_sync_w_d     = v_sync_w_q;
    hs_prev_d      = hs_prev_q;
    vs_prev_d      = vs_prev_q;
    line_bad_d     = line_bad_q;
    match_cnt_d    = match_cnt_q;
    sample_rgb_d   = sample_rgb_q;
    frame_done_d   = 1'b0;
    timing_err_d   = 1'b0;
    sample_valid_d = 1'b0;
    if (pix_en) begin
      hs_prev_d  = hsync_in;
      vs_prev_d  = vsync_in;
      h_cnt_d    = h_idx;
      v_cnt_d    = v_idx;
      line_bad_d = line_bad_q | line_err;
      if (hs_rise) h_total_d = h_meas;
      if (hs_rise) hs_w_d = CW'(1);
      else if (hsync_in) hs_w_d = sat_inc(hs_w_q);
      if (hs_fall) h_sync_w_d = hs_w_q;
      if (vs_rise) begin
        v_total_d = v_meas;
        vs_w_d    = hs_rise ? CW'(1) : '0;
      end else if (vsync_in && hs_rise) begin
        vs_w_d = sat_inc(vs_w_q);
      end
      if (vs_fall) v_sync_w_d = vs_w_q;

      case (state_q)
        S_SEARCH: begin
          if (vs_rise) state_d = S_MEASURE;
        end
        S_MEASURE, S_LOCKED: begin
          if (vs_rise) begin
            frame_done_d = 1'b1;
            line_bad_d   = 1'b0;
            if (!frame_ok) begin
              match_cnt_d  = '0;
              timing_err_d = 1'b1;
              state_d      = S_MEASURE;
            end else if (state_q == S_MEASURE) begin
              match_cnt_d = match_cnt_q + MW'(1);
              if (match_cnt_q + MW'(1) == LOCK_C) state_d = S_LOCKED;
            end
          end else if (h_idx == CNT_MAX || v_idx == CNT_MAX) begin
            // Sync lost: the state leaves MEASURE/LOCKED, so this fires once.
            timing_err_d = 1'b1;
            match_cnt_d  = '0;
            line_bad_d   = 1'b0;
            state_d      = S_SEARCH;
          end
        end
        default: state_d = S_SEARCH;
      endcase

      if (in_meas && h_idx == sample_x && v_idx == sample_y) begin
        sample_rgb_d   = {red_in, green_in, blue_in};
        sample_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_SEARCH;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      hs_w_q         <= '0;
      vs_w_q         <= '0;
      h_total_q      <= '0;
      v_total_q      <= '0;
      h_sync_w_q     <= '0;
      v_sync_w_q     <= '0;
      hs_prev_q      <= 1'b0;
      vs_prev_q      <= 1'b0;
      line_bad_q     <= 1'b0;
      match_cnt_q    <= '0;
      frame_done_q   <= 1'b0;
      timing_err_q   <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_rgb_q   <= '0;
    end else begin
      state_q        <= state_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      hs_w_q         <= hs_w_d;
      vs_w_q         <= vs_w_d;
      h_total_q      <= h_total_d;
      v_total_q      <= v_total_d;
      h_sync_w_q     <= h_sync_w_d;
      v_sync_w_q     <= v_sync_w_d;
      hs_prev_q      <= hs_prev_d;
      vs_prev_q      <= vs_prev_d;
      line_bad_q     <= line_bad_d;
      match_cnt_q    <= match_cnt_d;
      frame_done_q   <= frame_done_d;
      timing_err_q   <= timing_err_d;
      sample_valid_q <= sample_valid_d;
      sample_rgb_q   <= sample_rgb_d;
    end
  end

  assign h_total      = h_total_q;
  assign v_total      = v_total_q;
  assign h_sync_w     = h_sync_w_q;
  assign v_sync_w     = v_sync_w_q;
  assign locked       = (state_q == S_LOCKED);
  assign frame_done   = frame_done_q;
  assign timing_err   = timing_err_q;
  assign sample_rgb   = sample_rgb_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled 48x14 raster so many frames fit in a short run.
module tb_vga_timing_monitor;
  localparam int HT = 48, VT = 14, HS = 6, VS = 2, CW = 12;
  localparam int BX = 30, BY = 9;   // the single black pixel of every frame

  logic          clk = 1'b0, rst = 1'b1, pix_en = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [7:0]    red_in = '0, green_in = '0, blue_in = '0;
  logic [CW-1:0] sample_x = '0, sample_y = '0;
  logic [CW-1:0] h_total, v_total, h_sync_w, v_sync_w;
  logic          locked, frame_done, timing_err, sample_valid;
  logic [23:0]   sample_rgb;

  vga_timing_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
                       .LOCK_FRAMES(2), .CW(CW)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .sample_x(sample_x), .sample_y(sample_y),
    .h_total(h_total), .v_total(v_total), .h_sync_w(h_sync_w), .v_sync_w(v_sync_w),
    .locked(locked), .frame_done(frame_done), .timing_err(timing_err),
    .sample_rgb(sample_rgb), .sample_valid(sample_valid));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int fd_cnt = 0, te_cnt = 0, sv_cnt = 0;

  always @(negedge clk) begin
    if (frame_done)   fd_cnt++;
    if (timing_err)   te_cnt++;
    if (sample_valid) sv_cnt++;
  end

  // kind 0: frame (starting at pixel 1 of line 0, ending with the next frame's pixel 0)
  // kind 1: sync stall of 4200 dead pixels followed by a fresh vsync-rise pixel
  typedef struct {
    int kind; int lines; int short_y; int short_len; int sx; int sy; int gap;
    int e_ht; int e_vt; int e_hsw; int e_vsw; int e_lk; int e_fd; int e_te; int e_sv; int e_rgb;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pix(input bit hs, input bit vs, input int x, input int y, input int gap);
    int g;
    g = (gap == 0) ? int'($urandom_range(5, 1)) : gap;
    @(negedge clk);
    pix_en   = 1'b1;
    hsync_in = hs;
    vsync_in = vs;
    {red_in, green_in, blue_in} = (x == BX && y == BY) ? 24'h000000 : 24'hFFFFFF;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (g - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int nl, input int sh_y, input int sh_len, input int gap);
    for (int y = 0; y < nl; y++) begin
      int len;
      len = (y == sh_y) ? sh_len : HT;
      for (int x = (y == 0) ? 1 : 0; x < len; x++) pix(x < HS, y < VS, x, y, gap);
    end
    pix(1'b1, 1'b1, 0, 0, gap);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int fd0, te0, sv0;
    sample_x = CW'(v.sx);
    sample_y = CW'(v.sy);
    fd0 = fd_cnt; te0 = te_cnt; sv0 = sv_cnt;
    if (v.kind == 0) send_frame(v.lines, v.short_y, v.short_len, v.gap);
    else begin
      for (int x = 1; x <= 4200; x++) pix(1'b0, 1'b0, x, 0, v.gap);
      pix(1'b1, 1'b1, 0, 0, v.gap);
    end
    #1;
    chk({tag, ".h_total"},  int'(h_total),  v.e_ht);
    chk({tag, ".v_total"},  int'(v_total),  v.e_vt);
    chk({tag, ".h_sync_w"}, int'(h_sync_w), v.e_hsw);
    chk({tag, ".v_sync_w"}, int'(v_sync_w), v.e_vsw);
    chk({tag, ".locked"},   int'(locked),   v.e_lk);
    chk({tag, ".frame_done_pulses"},   fd_cnt - fd0, v.e_fd);
    chk({tag, ".timing_err_pulses"},   te_cnt - te0, v.e_te);
    chk({tag, ".sample_valid_pulses"}, sv_cnt - sv0, v.e_sv);
    chk({tag, ".sample_rgb"},  int'(sample_rgb), v.e_rgb);
    $display("%s: ht=%0d vt=%0d hsw=%0d vsw=%0d locked=%0b fd=%0d te=%0d sv=%0d rgb=%06h",
             tag, h_total, v_total, h_sync_w, v_sync_w, locked,
             fd_cnt - fd0, te_cnt - te0, sv_cnt - sv0, sample_rgb);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[14];
    vec_t post[2];
    int fd0, te0;
    //          kind lines sh_y sh_len sx  sy gap  ht  vt hsw vsw lk fd te sv rgb
    tbl[0]  = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  0, 1, 0, 1, 24'h000000};
    tbl[1]  = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  1, 1, 0, 1, 24'h000000};
    tbl[2]  = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  1, 1, 0, 1, 24'h000000};
    tbl[3]  = '{0,  14,   5,  47,   30, 9, 1,   48, 14, 6,  2,  0, 1, 1, 1, 24'h000000};
    tbl[4]  = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  0, 1, 0, 1, 24'h000000};
    tbl[5]  = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  1, 1, 0, 1, 24'h000000};
    tbl[6]  = '{0,  15,  -1,  0,    30, 9, 1,   48, 15, 6,  2,  0, 1, 1, 1, 24'h000000};
    tbl[7]  = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  0, 1, 0, 1, 24'h000000};
    tbl[8]  = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  1, 1, 0, 1, 24'h000000};
    tbl[9]  = '{0,  14,  -1,  0,    20, 5, 1,   48, 14, 6,  2,  1, 1, 0, 1, 24'hFFFFFF};
    tbl[10] = '{0,  14,  -1,  0,    30, 9, 0,   48, 14, 6,  2,  1, 1, 0, 1, 24'h000000};
    tbl[11] = '{1,  0,   -1,  0,    30, 9, 1,   0,  1,  1,  1,  0, 0, 1, 0, 24'h000000};
    tbl[12] = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  0, 1, 0, 1, 24'h000000};
    tbl[13] = '{0,  14,  -1,  0,    20, 5, 1,   48, 14, 6,  2,  1, 1, 0, 1, 24'hFFFFFF};
    post[0] = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  0, 1, 0, 1, 24'h000000};
    post[1] = '{0,  14,  -1,  0,    30, 9, 1,   48, 14, 6,  2,  1, 1, 0, 1, 24'h000000};

    // Power-on reset: every output must be zero.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.h_total",  int'(h_total),  0);
    chk("reset.v_total",  int'(v_total),  0);
    chk("reset.h_sync_w", int'(h_sync_w), 0);
    chk("reset.v_sync_w", int'(v_sync_w), 0);
    chk("reset.flags", int'({locked, frame_done, timing_err, sample_valid}), 0);
    chk("reset.sample_rgb", int'(sample_rgb), 0);
    $display("reset: outputs ht=%0d vt=%0d locked=%0b", h_total, v_total, locked);

    // First vsync rise only leaves SEARCH: no frame_done, no lock.
    fd0 = fd_cnt; te0 = te_cnt;
    sample_x = CW'(BX); sample_y = CW'(BY);
    pix(1'b1, 1'b1, 0, 0, 1);
    #1;
    chk("open.frame_done_pulses", fd_cnt - fd0, 0);
    chk("open.timing_err_pulses", te_cnt - te0, 0);
    chk("open.locked", int'(locked), 0);
    $display("open: first vsync rise, fd=%0d locked=%0b", fd_cnt - fd0, locked);

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of line 3 while locked, then let the frame run out.
    sample_x = CW'(BX); sample_y = CW'(BY);
    for (int y = 0; y < 3; y++)
      for (int x = (y == 0) ? 1 : 0; x < HT; x++) pix(x < HS, y < VS, x, y, 1);
    for (int x = 0; x < 20; x++) pix(1'b0, 1'b0, x, 3, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midrst.h_total",  int'(h_total),  0);
    chk("midrst.v_total",  int'(v_total),  0);
    chk("midrst.h_sync_w", int'(h_sync_w), 0);
    chk("midrst.v_sync_w", int'(v_sync_w), 0);
    chk("midrst.flags", int'({locked, frame_done, timing_err, sample_valid}), 0);
    chk("midrst.sample_rgb", int'(sample_rgb), 0);
    $display("midrst: outputs ht=%0d vt=%0d rgb=%06h locked=%0b", h_total, v_total, sample_rgb, locked);
    fd0 = fd_cnt; te0 = te_cnt;
    for (int x = 20; x < HT; x++) pix(1'b0, 1'b0, x, 3, 1);
    for (int y = 4; y < VT; y++)
      for (int x = 0; x < HT; x++) pix(x < HS, 1'b0, x, y, 1);
    pix(1'b1, 1'b1, 0, 0, 1);
    #1;
    chk("midrst_end.h_total", int'(h_total), 48);
    chk("midrst_end.v_total", int'(v_total), 11);
    chk("midrst_end.v_sync_w", int'(v_sync_w), 0);
    chk("midrst_end.locked", int'(locked), 0);
    chk("midrst_end.frame_done_pulses", fd_cnt - fd0, 0);
    chk("midrst_end.timing_err_pulses", te_cnt - te0, 0);
    $display("midrst_end: ht=%0d vt=%0d vsw=%0d locked=%0b", h_total, v_total, v_sync_w, locked);

    for (int i = 0; i < 2; i++) apply(post[i], $sformatf("relock%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
